// File: rtl/usb_cdc_rxctl_pkg.sv
// State encoding shared by the toggle-handshake receive controller.
package usb_cdc_rxctl_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/usb_synczer.sv
// Two-flop synchronizer for signals arriving from another clock domain.
// Both stages reset to DATA_ONRST so the first post-reset compare is quiet.
module usb_synczer #(
   parameter int                    DATA_WIDTH = 1,
   parameter logic [DATA_WIDTH-1:0] DATA_ONRST = '0
) (
   input  logic                  clock,
   input  logic                  reset0_async,
   input  logic                  reset0_sync,
   input  logic [DATA_WIDTH-1:0] data_async,
   output logic [DATA_WIDTH-1:0] data_sync
);

   logic [DATA_WIDTH-1:0] stage1;

   always_ff @(posedge clock or negedge reset0_async) begin
      if (!reset0_async) begin
         stage1    <= DATA_ONRST;
         data_sync <= DATA_ONRST;
      end else if (!reset0_sync) begin
         stage1    <= DATA_ONRST;
         data_sync <= DATA_ONRST;
      end else begin
         stage1    <= data_async;
         data_sync <= stage1;
      end
   end

endmodule

// File: rtl/usb_cdc_rxctl.sv
// Destination side of a two-phase req/ack word crossing: captures the held
// source word, offers it via valid/ready and toggles ack once it is accepted.
module usb_cdc_rxctl #(
   parameter int   DATA_WIDTH = 8,
   parameter int   CNT_WIDTH  = 8,
   parameter logic REQ_ONRST  = 1'b0
) (
   input  logic                  reset0_async,
   input  logic                  clock,
   input  logic                  reset0_sync,
   input  logic                  req_toggle_async,
   input  logic [DATA_WIDTH-1:0] data_async,
   output logic                  ack_toggle,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   input  logic                  overrun_clr,
   output logic                  overrun,
   output logic [CNT_WIDTH-1:0]  xfer_cnt
);

   import usb_cdc_rxctl_pkg::*;

   state_t state;
   state_t next_state;
   logic   req_sync;
   logic   req_sync_d;
   logic   req_seen;
   logic   capture;
   logic   accept;
   logic   req_edge;

   usb_synczer #(
      .DATA_WIDTH (1),
      .DATA_ONRST (REQ_ONRST)
   ) u_req_synczer (
      .clock        (clock),
      .reset0_async (reset0_async),
      .reset0_sync  (reset0_sync),
      .data_async   (req_toggle_async),
      .data_sync    (req_sync)
   );

   // A fresh request is a mismatch against the level we last acknowledged.
   always_comb begin
      next_state = state;
      capture    = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (req_sync != req_seen) begin
               capture    = 1'b1;
               next_state = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               accept     = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign req_edge = (state == HOLD) && (req_sync != req_sync_d);

   always_ff @(posedge clock or negedge reset0_async) begin
      if (!reset0_async) begin
         state <= IDLE;
      end else if (!reset0_sync) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge clock or negedge reset0_async) begin
      if (!reset0_async) begin
         req_sync_d <= REQ_ONRST;
         req_seen   <= REQ_ONRST;
         ack_toggle <= 1'b0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         xfer_cnt   <= '0;
      end else if (!reset0_sync) begin
         req_sync_d <= REQ_ONRST;
         req_seen   <= REQ_ONRST;
         ack_toggle <= 1'b0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         xfer_cnt   <= '0;
      end else begin
         req_sync_d <= req_sync;
         if (capture) begin
            out_data  <= data_async;
            out_valid <= 1'b1;
         end else if (accept) begin
            out_valid  <= 1'b0;
            ack_toggle <= ~ack_toggle;
            req_seen   <= ~req_seen;
            xfer_cnt   <= xfer_cnt + 1'b1;
         end
      end
   end

   // A second source toggle while a word is held only flags; set beats clear.
   always_ff @(posedge clock or negedge reset0_async) begin
      if (!reset0_async) begin
         overrun <= 1'b0;
      end else if (!reset0_sync) begin
         overrun <= 1'b0;
      end else if (req_edge) begin
         overrun <= 1'b1;
      end else if (overrun_clr) begin
         overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_usb_cdc_rxctl.sv
// Directed bench for usb_cdc_rxctl: inputs driven and outputs sampled on the
// falling clock edge, expected values hand-computed.
module tb_usb_cdc_rxctl;

   localparam int DW = 8;
   localparam int CW = 4;

   logic          clock = 1'b0;
   logic          reset0_async;
   logic          reset0_sync;
   logic          req_toggle_async;
   logic [DW-1:0] data_async;
   logic          ack_toggle;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          overrun_clr;
   logic          overrun;
   logic [CW-1:0] xfer_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [DW-1:0] data;
      int            ready_delay;
      logic [DW-1:0] exp_data;
      logic [CW-1:0] exp_cnt;
      logic          exp_ack;
   } vec_t;

   vec_t vecs [5];

   always #5 clock = ~clock;

   usb_cdc_rxctl #(
      .DATA_WIDTH (DW),
      .CNT_WIDTH  (CW),
      .REQ_ONRST  (1'b0)
   ) dut (
      .reset0_async     (reset0_async),
      .clock            (clock),
      .reset0_sync      (reset0_sync),
      .req_toggle_async (req_toggle_async),
      .data_async       (data_async),
      .ack_toggle       (ack_toggle),
      .out_data         (out_data),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .overrun_clr      (overrun_clr),
      .overrun          (overrun),
      .xfer_cnt         (xfer_cnt)
   );

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [DW-1:0] word);
      data_async       = word;
      req_toggle_async = ~req_toggle_async;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!out_valid && n < 8) begin
         @(negedge clock);
         n++;
      end
      check_output({name, "_valid_seen"}, 32'(out_valid), 32'd1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset0_async     = 1'b0;
      reset0_sync      = 1'b1;
      req_toggle_async = 1'b0;
      data_async       = '0;
      out_ready        = 1'b0;
      overrun_clr      = 1'b0;

      vecs[0] = '{data: 8'h00, ready_delay: 0, exp_data: 8'h00, exp_cnt: 4'd3, exp_ack: 1'b1};
      vecs[1] = '{data: 8'hFF, ready_delay: 2, exp_data: 8'hFF, exp_cnt: 4'd4, exp_ack: 1'b0};
      vecs[2] = '{data: 8'h81, ready_delay: 1, exp_data: 8'h81, exp_cnt: 4'd5, exp_ack: 1'b1};
      vecs[3] = '{data: 8'h7E, ready_delay: 0, exp_data: 8'h7E, exp_cnt: 4'd6, exp_ack: 1'b0};
      vecs[4] = '{data: 8'hC3, ready_delay: 3, exp_data: 8'hC3, exp_cnt: 4'd7, exp_ack: 1'b1};

      repeat (2) @(negedge clock);
      check_output("rst_valid", 32'(out_valid), 32'd0);
      check_output("rst_ack", 32'(ack_toggle), 32'd0);
      check_output("rst_data", 32'(out_data), 32'd0);
      check_output("rst_overrun", 32'(overrun), 32'd0);
      check_output("rst_cnt", 32'(xfer_cnt), 32'd0);
      reset0_async = 1'b1;
      @(negedge clock);

      // First word: three-edge latency, then a one-cycle valid pulse.
      out_ready = 1'b1;
      apply_stimulus(8'hA5);
      @(negedge clock);
      check_output("lat_k_valid", 32'(out_valid), 32'd0);
      @(negedge clock);
      check_output("lat_k1_valid", 32'(out_valid), 32'd0);
      @(negedge clock);
      check_output("lat_k2_valid", 32'(out_valid), 32'd1);
      check_output("lat_k2_data", 32'(out_data), 32'hA5);
      check_output("lat_k2_ack", 32'(ack_toggle), 32'd0);
      @(negedge clock);
      check_output("pulse_end_valid", 32'(out_valid), 32'd0);
      check_output("first_ack", 32'(ack_toggle), 32'd1);
      check_output("first_cnt", 32'(xfer_cnt), 32'd1);

      // Backpressure with the source word changing underneath.
      out_ready = 1'b0;
      apply_stimulus(8'hA5);
      wait_valid("bp");
      check_output("bp_data", 32'(out_data), 32'hA5);
      data_async = 8'h3C;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         check_output("bp_hold_valid", 32'(out_valid), 32'd1);
         check_output("bp_hold_data", 32'(out_data), 32'hA5);
         check_output("bp_hold_ack", 32'(ack_toggle), 32'd1);
      end
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      check_output("bp_accept_valid", 32'(out_valid), 32'd0);
      check_output("bp_accept_ack", 32'(ack_toggle), 32'd0);
      check_output("bp_accept_cnt", 32'(xfer_cnt), 32'd2);

      for (int i = 0; i < 5; i++) begin
         apply_stimulus(vecs[i].data);
         wait_valid("vec");
         check_output("vec_data", 32'(out_data), 32'(vecs[i].exp_data));
         for (int d = 0; d < vecs[i].ready_delay; d++) begin
            @(negedge clock);
            check_output("vec_hold_valid", 32'(out_valid), 32'd1);
         end
         out_ready = 1'b1;
         @(negedge clock);
         out_ready = 1'b0;
         check_output("vec_done_valid", 32'(out_valid), 32'd0);
         check_output("vec_cnt", 32'(xfer_cnt), 32'(vecs[i].exp_cnt));
         check_output("vec_ack", 32'(ack_toggle), 32'(vecs[i].exp_ack));
      end
      check_output("vec_no_overrun", 32'(overrun), 32'd0);

      // Overrun: extra toggles while held, then clear racing a set.
      apply_stimulus(8'h11);
      wait_valid("ovr");
      check_output("ovr_pre", 32'(overrun), 32'd0);
      apply_stimulus(8'h22);
      repeat (3) @(negedge clock);
      check_output("ovr_set", 32'(overrun), 32'd1);
      check_output("ovr_data_kept", 32'(out_data), 32'h11);
      check_output("ovr_valid_kept", 32'(out_valid), 32'd1);
      check_output("ovr_no_ack", 32'(ack_toggle), 32'd1);
      apply_stimulus(8'h33);
      repeat (2) @(negedge clock);
      overrun_clr = 1'b1;
      @(negedge clock);
      overrun_clr = 1'b0;
      check_output("ovr_set_wins", 32'(overrun), 32'd1);
      overrun_clr = 1'b1;
      @(negedge clock);
      overrun_clr = 1'b0;
      check_output("ovr_cleared", 32'(overrun), 32'd0);
      check_output("ovr_data_still", 32'(out_data), 32'h11);

      // Synchronous reset while holding, source back to its reset level.
      reset0_sync      = 1'b0;
      req_toggle_async = 1'b0;
      @(negedge clock);
      reset0_sync = 1'b1;
      check_output("srst_valid", 32'(out_valid), 32'd0);
      check_output("srst_ack", 32'(ack_toggle), 32'd0);
      check_output("srst_data", 32'(out_data), 32'd0);
      check_output("srst_cnt", 32'(xfer_cnt), 32'd0);
      check_output("srst_overrun", 32'(overrun), 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check_output("srst_no_capture", 32'(out_valid), 32'd0);
      end

      // Seventeen back-to-back words wrap the 4-bit counter to 1.
      out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         logic [DW-1:0] word;
         word = 8'(i * 37 + 5);
         apply_stimulus(word);
         wait_valid("wrap");
         check_output("wrap_data", 32'(out_data), 32'(word));
         @(negedge clock);
      end
      out_ready = 1'b0;
      check_output("wrap_valid", 32'(out_valid), 32'd0);
      check_output("wrap_cnt", 32'(xfer_cnt), 32'd1);
      check_output("wrap_ack", 32'(ack_toggle), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
